// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the MMIO UART receiver
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_t;

  localparam int ST_AVAIL = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_FRM   = 3;
  localparam int ST_PAR   = 4;

  localparam logic [15:0] OFS_DATA   = 16'd0;
  localparam logic [15:0] OFS_STATUS = 16'd1;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_mmio_if.sv
// rtl/uart_rx_mmio_if.sv - MMIO request/done bus between core and receiver
interface uart_rx_mmio_if;
  logic [15:0] mmio_addr;
  logic [7:0]  mmio_data;
  logic        mmio_write;
  logic        mmio_req;
  logic        mmio_done;
  logic [7:0]  mmio_rdata;

  modport master (
    output mmio_addr, mmio_data, mmio_write, mmio_req,
    input  mmio_done, mmio_rdata
  );

  modport slave (
    input  mmio_addr, mmio_data, mmio_write, mmio_req,
    output mmio_done, mmio_rdata
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous FIFO with registered head and occupancy count
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [AW:0]      count_next;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    rd_next    = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
    count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      // The incoming byte becomes the head when it lands in the slot the read pointer is moving to.
      if (count_next != '0)
        head <= (push_ok && (wr_ptr == rd_next)) ? din : mem[rd_next];
    end
  end
endmodule

// File: rtl/uart_rx_mmio.sv
// rtl/uart_rx_mmio.sv - memory-mapped 8N1 UART receiver; define UART_RX_PARITY_EN for even parity
module uart_rx_mmio
  import uart_rx_pkg::*;
#(
  parameter int          CLK_FREQ   = 27_000_000,
  parameter int          BAUD       = 115200,
  parameter logic [15:0] BASE_ADDR  = 16'hF010,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  uart_rx_mmio_if.slave  bus,
  input  logic           rx,
  output logic           rx_avail
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES + 1);
  localparam int NW         = $clog2(FIFO_DEPTH) + 1;

  logic rx_meta, rx_sync, rx_prev, fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  rx_state_t      state, state_next;
  logic [CW-1:0]  cyc;
  logic [2:0]     bit_idx;
  logic [7:0]     shift, push_byte;
  logic           half_tick, bit_tick, cyc_clr, shift_en;
  logic           push_req, push_pend, frm_set;
`ifdef UART_RX_PARITY_EN
  logic           par_set;
`endif

  assign half_tick = (cyc == CW'(HALF - 1));
  assign bit_tick  = (cyc == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (fall) state_next = START;
      START: if (half_tick) state_next = rx_sync ? IDLE : DATA;
      DATA:  if (bit_tick && bit_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
               state_next = PARITY;
      PARITY: if (bit_tick) state_next = STOP;
`else
               state_next = STOP;
`endif
      STOP:  if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cyc_clr  = bit_tick || (state_next != state);
    shift_en = 1'b0;
    push_req = 1'b0;
    frm_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set  = 1'b0;
`endif
    case (state)
      DATA: shift_en = bit_tick;
`ifdef UART_RX_PARITY_EN
      PARITY: par_set = bit_tick && (rx_sync != even_parity(shift));
`endif
      STOP: begin
        push_req = bit_tick && rx_sync;
        frm_set  = bit_tick && !rx_sync;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      push_pend <= 1'b0;
      push_byte <= '0;
    end else begin
      cyc <= cyc_clr ? '0 : cyc + 1'b1;
      if (state == IDLE)  bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 1'b1;
      if (shift_en) shift <= {rx_sync, shift[7:1]};
      push_pend <= push_req;
      if (push_req) push_byte <= shift;
    end
  end

  logic [7:0]    fifo_head, status, stat_clr;
  logic [NW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          hit_data, hit_stat, respond, armed, rd_pop, ovr_set;
  logic          ovr, frm, par_err;

  assign hit_data = (bus.mmio_addr == BASE_ADDR + OFS_DATA);
  assign hit_stat = (bus.mmio_addr == BASE_ADDR + OFS_STATUS);
  assign respond  = bus.mmio_req && armed && (hit_data || hit_stat);
  assign rd_pop   = respond && hit_data && !bus.mmio_write && !fifo_empty;
  assign stat_clr = (respond && hit_stat && bus.mmio_write) ? bus.mmio_data : 8'h00;
  // A push into a full FIFO survives only if a pop lands on the same edge.
  assign ovr_set  = push_pend && fifo_full && !rd_pop;
  assign rx_avail = (fifo_count != '0);

  uart_rx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_pend),
    .din   (push_byte),
    .pop   (rd_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status           = 8'h00;
    status[ST_AVAIL] = rx_avail;
    status[ST_FULL]  = fifo_full;
    status[ST_OVR]   = ovr;
    status[ST_FRM]   = frm;
    status[ST_PAR]   = par_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovr <= 1'b0;
      frm <= 1'b0;
    end else begin
      ovr <= (ovr & ~stat_clr[ST_OVR]) | ovr_set;
      frm <= (frm & ~stat_clr[ST_FRM]) | frm_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset) par_err <= 1'b0;
    else       par_err <= (par_err & ~stat_clr[ST_PAR]) | par_set;
  end
  logic unused_bits;
  assign unused_bits = ^{stat_clr[7:5], stat_clr[1:0]};
`else
  assign par_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{stat_clr[7:4], stat_clr[1:0]};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mmio_done  <= 1'b0;
      bus.mmio_rdata <= 8'h00;
      armed          <= 1'b1;
    end else begin
      bus.mmio_done <= respond;
      if (!bus.mmio_req) armed <= 1'b1;
      else if (respond)  armed <= 1'b0;
      if (respond && !bus.mmio_write)
        bus.mmio_rdata <= hit_data ? (fifo_empty ? 8'h00 : fifo_head) : status;
    end
  end
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb/tb_uart_rx_mmio.sv - scoreboard bench for uart_rx_mmio at default parameters
module tb_uart_rx_mmio;
  localparam int          BIT    = 27_000_000 / 115200;
  localparam logic [15:0] A_DATA = 16'hF010;
  localparam logic [15:0] A_STAT = 16'hF011;

  logic clock = 1'b0;
  logic reset, rx, rx_avail;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [7:0] exp_q [$];

  uart_rx_mmio_if bus ();

  uart_rx_mmio dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .rx       (rx),
    .rx_avail (rx_avail)
  );

  always #5 clock = ~clock;

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b);
    @(negedge clock);
    rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clock);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_b;
    repeat (BIT) @(negedge clock);
`else
    if (par_b === 1'bx) rx = 1'b1;
`endif
    rx = stop_b;
    repeat (BIT) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1, ^b);
  endtask

  task automatic mmio_xfer(input logic [15:0] a, input logic wr, input logic [7:0] wd,
                           output logic [7:0] rd);
    int t;
    @(negedge clock);
    bus.mmio_addr  = a;
    bus.mmio_write = wr;
    bus.mmio_data  = wd;
    bus.mmio_req   = 1'b1;
    t = 0;
    do begin
      @(posedge clock);
      #1;
      t++;
    end while (!bus.mmio_done && t < 20);
    if (!bus.mmio_done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL mmio_timeout: addr %h got no done, required done within 20 cycles", a);
    end
    rd = bus.mmio_rdata;
    @(negedge clock);
    bus.mmio_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rx = 1'b1;
    reset = 1'b1;
    bus.mmio_addr = '0; bus.mmio_data = '0; bus.mmio_write = 1'b0; bus.mmio_req = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (bus.mmio_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", bus.mmio_done); end
    n_cmp++; if (bus.mmio_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h required 00", bus.mmio_rdata); end
    n_cmp++; if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL reset_avail: got %b required 0", rx_avail); end
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("reset_status", d, 8'h00);
  endtask

  task automatic test_basic();
    logic [7:0] d;
    send_good(8'hA5);
    repeat (5) @(negedge clock);
    n_cmp++; if (rx_avail !== 1'b1) begin n_fail++; $display("FAIL basic_avail: got %b required 1", rx_avail); end
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("basic_status", d, 8'h01);
    mmio_xfer(A_DATA, 1'b0, 8'h00, d);
    check8("basic_data", d, exp_q.pop_front());
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("basic_status_after", d, 8'h00);
    n_cmp++; if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL basic_avail_after: got %b required 0", rx_avail); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    @(negedge clock);
    rx = 1'b0;
    repeat (50) @(negedge clock);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clock);
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("glitch_status", d, 8'h00);
    n_cmp++; if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL glitch_avail: got %b required 0", rx_avail); end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    repeat (BIT) @(negedge clock);
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("frame_status", d, 8'h08);
    mmio_xfer(A_DATA, 1'b0, 8'h00, d);
    check8("frame_data_empty", d, 8'h00);
    mmio_xfer(A_STAT, 1'b1, 8'h08, d);
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("frame_status_cleared", d, 8'h00);
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) send_good(8'(i));
      else        send_frame(8'(i), 1'b1, ^8'(i));
    end
    repeat (10) @(negedge clock);
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("ovr_status_full", d, 8'h07);
    for (int i = 0; i < 16; i++) begin
      mmio_xfer(A_DATA, 1'b0, 8'h00, d);
      check8($sformatf("ovr_data_%0d", i), d, exp_q.pop_front());
    end
    mmio_xfer(A_DATA, 1'b0, 8'h00, d);
    check8("ovr_data_empty", d, 8'h00);
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("ovr_status_drained", d, 8'h04);
    mmio_xfer(A_STAT, 1'b1, 8'h04, d);
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("ovr_status_cleared", d, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, got;
    int pulses;
    send_good(8'h11);
    send_good(8'h22);
    repeat (10) @(negedge clock);
    bus.mmio_addr = A_DATA; bus.mmio_write = 1'b0; bus.mmio_req = 1'b1;
    pulses = 0;
    got = 8'h00;
    repeat (10) begin
      @(posedge clock); #1;
      if (bus.mmio_done) begin pulses++; got = bus.mmio_rdata; end
    end
    @(negedge clock);
    bus.mmio_req = 1'b0;
    @(negedge clock);
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL held_done_pulses: got %0d required 1", pulses); end
    check8("held_data", got, exp_q.pop_front());
    mmio_xfer(A_DATA, 1'b0, 8'h00, d);
    check8("held_next_data", d, exp_q.pop_front());
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("held_status", d, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, b;
    b = 8'h77;
    @(negedge clock);
    rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clock);
    end
    rx = b[4];
    repeat (BIT / 2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clock);
    send_good(8'h5A);
    repeat (10) @(negedge clock);
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("rstmid_status", d, 8'h01);
    mmio_xfer(A_DATA, 1'b0, 8'h00, d);
    check8("rstmid_data", d, exp_q.pop_front());
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("rstmid_status_after", d, 8'h00);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (10) @(negedge clock);
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("parity_status", d, 8'h11);
    mmio_xfer(A_DATA, 1'b0, 8'h00, d);
    check8("parity_data", d, exp_q.pop_front());
    mmio_xfer(A_STAT, 1'b1, 8'h10, d);
    mmio_xfer(A_STAT, 1'b0, 8'h00, d);
    check8("parity_status_cleared", d, 8'h00);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
